alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
Multi-cycle shift-and-add 16-bit multiplier controller that borrows the shared ALU for its additions. It also arbitrates ALU control between the main control unit (pass-through) and itself.
While busy it owns AluOp/SrcA/SrcB and the A/B data lines (mary, shelley). The main control must stall on busy.
Result is the low 16 bits of the product, plus a sticky overflow flag.

Parameters:
WIDTH, 16, operand/ALU width; fixed to the ALU datapath width.
CNT_W, 5, iteration counter width; must hold WIDTH.
ALU_ADD, 4'b0010, AluOp encoding driven for additions.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
start  in  1  request; sampled only in IDLE
op_a  in  16  multiplicand
op_b  in  16  multiplier
alu_out  in  16  registered ALU result (1-cycle latency after inputs driven)
ctl_src_a  in  1  main-control SrcA
ctl_src_b  in  2  main-control SrcB
ctl_alu_op  in  4  main-control AluOp
ctl_mary  in  16  main-datapath A data
ctl_shelley  in  16  main-datapath B data
alu_src_a  out  1  to ALU SrcA
alu_src_b  out  2  to ALU SrcB
alu_op  out  4  to ALU AluOp
alu_mary  out  16  to ALU mary input
alu_shelley  out  16  to ALU shelley input
busy  out  1  sequencer owns the ALU
done  out  1  one-cycle pulse; product valid
product  out  16  low 16 bits of op_a*op_b; held until next accepted start
mul_ovf  out  1  true product exceeded 16 bits; held with product

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, product=0, mul_ovf=0. Internal acc, mcand, mplier, count and lost are all 0.
- States: IDLE, CHECK, ISSUE, CAPTURE, DONE. busy=1 in CHECK, ISSUE, CAPTURE and DONE.
- IDLE: start=1 latches mcand=op_a, mplier=op_b, acc=0, count=0, lost=0, ovf=0, then goes to CHECK. start=0 stays in IDLE.
- CHECK: if count==WIDTH, or (early-term enabled and mplier==0), go to DONE.
- CHECK: else if mplier[0]=1, go to ISSUE.
- CHECK: else shift: mcand<<=1 (lost|=mcand[15]), mplier>>=1, count++, stay in CHECK.
- ISSUE: alu_src_a=0, alu_src_b=2'b00, alu_op=ALU_ADD, alu_mary=acc, alu_shelley=mcand. Set ovf if lost=1 or acc+mcand>16'hFFFF (local 17-bit carry compare). Go to CAPTURE.
- CAPTURE: acc<=alu_out, then the shift step (as in CHECK), count++, go to CHECK. ALU outputs hold the ISSUE values.
- DONE: product<=acc, mul_ovf<=ovf, done=1 for this cycle only, go to IDLE.
- Grant mux: in IDLE the alu_* outputs equal the ctl_* inputs combinationally. In any other state the sequencer drives them; in CHECK/DONE it drives zeros with alu_op=ALU_ADD.
- start while busy: ignored, no queuing. Operand changes after acceptance have no effect.
- Latency, start sampled at edge 0: done asserts in cycle 3*ones + zeros_processed + 2.
- Reset mid-operation: immediate return to IDLE; product and mul_ovf cleared; grant returns to main control.

Optional Feature:
MULSEQ_EARLY_TERM_EN
- Defined: CHECK exits to DONE as soon as mplier==0.
- Undefined: always runs WIDTH iterations (each zero bit costs one CHECK cycle). Results are identical; only latency differs.

Decomposition:
- Shared package (alu_pkg): AluOp encodings (AND..SRL), SrcA/SrcB encodings, WIDTH constant, sequencer state enum.
- One sub-module: alu_grant_mux, the combinational selection of the ctl_* vs sequencer drive, keyed on busy.

Test Plan:
- Reset: hold reset=0 mid-run → busy=0, product=0, mul_ovf=0; alu_op follows ctl_alu_op.
- 3*5, early-term on: start → ISSUE in cycles 2 and 6 with alu_mary/alu_shelley = 0/3 and 3/12; done in cycle 9; product=15, mul_ovf=0.
- 0x1234*0, early-term on → done in cycle 2, product=0. Early-term off → done in cycle 18.
- 0xFFFF*0xFFFF (either build) → done in cycle 50, product=0x0001, mul_ovf=1.
- 0x0100*0x0100 → product=0x0000, mul_ovf=1. 0x00FF*0x0101 → product=0xFFFF, mul_ovf=0.
- Pass-through and ignore: in IDLE, ctl_alu_op=4'b1000 appears on alu_op. A start pulse mid-run does not perturb the result; back-to-back start in the cycle after done is accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions for the datapath slice.
// Contents: ALU datapath width, AluOp encodings (AND..SRL), SrcA/SrcB
// select encodings, and the multiplier sequencer state enum.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    // AluOp encodings
    localparam logic [3:0] ALU_OP_AND = 4'b0000;
    localparam logic [3:0] ALU_OP_OR  = 4'b0001;
    localparam logic [3:0] ALU_OP_ADD = 4'b0010;
    localparam logic [3:0] ALU_OP_SLL = 4'b0011;
    localparam logic [3:0] ALU_OP_SUB = 4'b0110;
    localparam logic [3:0] ALU_OP_SLT = 4'b0111;
    localparam logic [3:0] ALU_OP_SRL = 4'b1000;

    // SrcA / SrcB select encodings
    localparam logic       ALU_SRCA_PC   = 1'b0;
    localparam logic       ALU_SRCA_REG  = 1'b1;
    localparam logic [1:0] ALU_SRCB_REG  = 2'b00;
    localparam logic [1:0] ALU_SRCB_FOUR = 2'b01;
    localparam logic [1:0] ALU_SRCB_IMM  = 2'b10;
    localparam logic [1:0] ALU_SRCB_BR   = 2'b11;

    typedef enum logic [2:0] {
        MULSEQ_IDLE,
        MULSEQ_CHECK,
        MULSEQ_ISSUE,
        MULSEQ_CAPTURE,
        MULSEQ_DONE
    } mulseq_state_t;

endpackage

// File: rtl/alu_grant_mux.sv
// ALU control grant mux: selects between main-control drive (ctl_*) and
// multiplier sequencer drive (seq_*) for the shared ALU, keyed on busy.
// Ports:
//   busy            - 1 selects the sequencer, 0 the main control
//   ctl_*           - main-control SrcA/SrcB/AluOp/mary/shelley
//   seq_*           - sequencer SrcA/SrcB/AluOp/mary/shelley
//   alu_*           - selected drive to the ALU
module alu_grant_mux #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             busy,
    input  logic             ctl_src_a,
    input  logic [1:0]       ctl_src_b,
    input  logic [3:0]       ctl_alu_op,
    input  logic [WIDTH-1:0] ctl_mary,
    input  logic [WIDTH-1:0] ctl_shelley,
    input  logic             seq_src_a,
    input  logic [1:0]       seq_src_b,
    input  logic [3:0]       seq_alu_op,
    input  logic [WIDTH-1:0] seq_mary,
    input  logic [WIDTH-1:0] seq_shelley,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_mary,
    output logic [WIDTH-1:0] alu_shelley
);

    always_comb begin
        if (busy) begin
            alu_src_a   = seq_src_a;
            alu_src_b   = seq_src_b;
            alu_op      = seq_alu_op;
            alu_mary    = seq_mary;
            alu_shelley = seq_shelley;
        end else begin
            alu_src_a   = ctl_src_a;
            alu_src_b   = ctl_src_b;
            alu_op      = ctl_alu_op;
            alu_mary    = ctl_mary;
            alu_shelley = ctl_shelley;
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared ALU for its
// additions and arbitrates ALU control against the main control unit.
// Build option: define MULSEQ_EARLY_TERM_EN to finish as soon as the
// remaining multiplier bits are zero (results identical, lower latency).
// Ports:
//   clock, reset              - rising-edge clock, async active-low reset
//   start, op_a, op_b         - request with multiplicand / multiplier
//   alu_out                   - registered ALU result (1-cycle latency)
//   ctl_*                     - main-control ALU drive (passed through in IDLE)
//   alu_*                     - granted ALU drive
//   busy                      - sequencer owns the ALU
//   done                      - one-cycle pulse, product/mul_ovf valid
//   product, mul_ovf          - low product bits and overflow, held
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = ALU_WIDTH,
    parameter int unsigned CNT_W   = 5,
    parameter logic [3:0]  ALU_ADD = ALU_OP_ADD
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             ctl_src_a,
    input  logic [1:0]       ctl_src_b,
    input  logic [3:0]       ctl_alu_op,
    input  logic [WIDTH-1:0] ctl_mary,
    input  logic [WIDTH-1:0] ctl_shelley,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_mary,
    output logic [WIDTH-1:0] alu_shelley,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             mul_ovf
);

    mulseq_state_t    state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lost_q, lost_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             mul_ovf_q, mul_ovf_d;

    logic             do_shift;
    logic             early_term;
    logic             carry;
    logic             seq_src_a;
    logic [1:0]       seq_src_b;
    logic [3:0]       seq_alu_op;
    logic [WIDTH-1:0] seq_mary;
    logic [WIDTH-1:0] seq_shelley;

`ifdef MULSEQ_EARLY_TERM_EN
    assign early_term = (mplier_q == '0);
`else
    assign early_term = 1'b0;
`endif

    // Carry out of acc+mcand, computed locally so overflow does not depend
    // on the ALU exposing a carry flag.
    assign carry = ({1'b0, acc_q} + {1'b0, mcand_q}) > {1'b0, {WIDTH{1'b1}}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= MULSEQ_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            lost_q    <= 1'b0;
            ovf_q     <= 1'b0;
            product_q <= '0;
            mul_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            lost_q    <= lost_d;
            ovf_q     <= ovf_d;
            product_q <= product_d;
            mul_ovf_q <= mul_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        lost_d      = lost_q;
        ovf_d       = ovf_q;
        product_d   = product_q;
        mul_ovf_d   = mul_ovf_q;
        do_shift    = 1'b0;
        seq_src_a   = ALU_SRCA_PC;
        seq_src_b   = ALU_SRCB_REG;
        seq_alu_op  = ALU_ADD;
        seq_mary    = '0;
        seq_shelley = '0;

        case (state_q)
            MULSEQ_IDLE: begin
                if (start) begin
                    state_d  = MULSEQ_CHECK;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    count_d  = '0;
                    lost_d   = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            MULSEQ_CHECK: begin
                if ((count_q == CNT_W'(WIDTH)) || early_term) begin
                    state_d   = MULSEQ_DONE;
                    // acc is final here; loading now makes product valid
                    // in the same cycle as the done pulse.
                    product_d = acc_q;
                    mul_ovf_d = ovf_q;
                end else if (mplier_q[0]) begin
                    state_d = MULSEQ_ISSUE;
                end else begin
                    do_shift = 1'b1;
                end
            end
            MULSEQ_ISSUE: begin
                seq_mary    = acc_q;
                seq_shelley = mcand_q;
                if (lost_q || carry) begin
                    ovf_d = 1'b1;
                end
                state_d = MULSEQ_CAPTURE;
            end
            MULSEQ_CAPTURE: begin
                seq_mary    = acc_q;
                seq_shelley = mcand_q;
                acc_d       = alu_out;
                do_shift    = 1'b1;
                state_d     = MULSEQ_CHECK;
            end
            MULSEQ_DONE: begin
                state_d = MULSEQ_IDLE;
            end
            default: begin
                state_d = MULSEQ_IDLE;
            end
        endcase

        if (do_shift) begin
            lost_d   = lost_q | mcand_q[WIDTH-1];
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    assign busy    = (state_q != MULSEQ_IDLE);
    assign done    = (state_q == MULSEQ_DONE);
    assign product = product_q;
    assign mul_ovf = mul_ovf_q;

    alu_grant_mux #(
        .WIDTH (WIDTH)
    ) u_grant (
        .busy        (busy),
        .ctl_src_a   (ctl_src_a),
        .ctl_src_b   (ctl_src_b),
        .ctl_alu_op  (ctl_alu_op),
        .ctl_mary    (ctl_mary),
        .ctl_shelley (ctl_shelley),
        .seq_src_a   (seq_src_a),
        .seq_src_b   (seq_src_b),
        .seq_alu_op  (seq_alu_op),
        .seq_mary    (seq_mary),
        .seq_shelley (seq_shelley),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .alu_mary    (alu_mary),
        .alu_shelley (alu_shelley)
    );

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a registered ALU model,
// a cycle-level behavioural reference and directed literal cases.
module tb_alu_mul_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [15:0] alu_out = '0;
    logic        ctl_src_a = 1'b0;
    logic [1:0]  ctl_src_b = '0;
    logic [3:0]  ctl_alu_op = '0;
    logic [15:0] ctl_mary = '0;
    logic [15:0] ctl_shelley = '0;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_mary;
    logic [15:0] alu_shelley;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        mul_ovf;

    alu_mul_sequencer #(
        .WIDTH   (16),
        .CNT_W   (5),
        .ALU_ADD (4'b0010)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_out     (alu_out),
        .ctl_src_a   (ctl_src_a),
        .ctl_src_b   (ctl_src_b),
        .ctl_alu_op  (ctl_alu_op),
        .ctl_mary    (ctl_mary),
        .ctl_shelley (ctl_shelley),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .alu_mary    (alu_mary),
        .alu_shelley (alu_shelley),
        .busy        (busy),
        .done        (done),
        .product     (product),
        .mul_ovf     (mul_ovf)
    );

    always #5 clock = ~clock;

    // Registered ALU: result visible one cycle after its inputs.
    always @(posedge clock) begin
        case (alu_op)
            4'b0010: alu_out <= alu_mary + alu_shelley;
            4'b0000: alu_out <= alu_mary & alu_shelley;
            4'b0001: alu_out <= alu_mary | alu_shelley;
            4'b0110: alu_out <= alu_mary - alu_shelley;
            default: alu_out <= alu_mary;
        endcase
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycles from acceptance to done: each one bit costs ISSUE+CAPTURE+CHECK,
    // each processed zero bit one CHECK, plus the final CHECK and DONE.
    function automatic int unsigned lat_of(input logic [15:0] b);
        int unsigned ones;
        int unsigned zeros;
        int msb;
        ones = $countones(b);
`ifdef MULSEQ_EARLY_TERM_EN
        msb = -1;
        for (int i = 0; i < 16; i++) if (b[i]) msb = i;
        zeros = (b == 16'h0) ? 0 : (int'(msb) + 1 - ones);
`else
        msb = 0;
        zeros = 16 - ones;
`endif
        return 3 * ones + zeros + 2;
    endfunction

    // Reference model: rem counts down the cycles of an accepted request;
    // rem==1 is the done cycle, rem==0 is idle.
    int unsigned rem = 0;
    logic [31:0] full_m = '0;
    logic [15:0] pend_p = '0;
    logic        pend_o = 1'b0;
    logic [15:0] exp_p = '0;
    logic        exp_o = 1'b0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem   = 0;
            exp_p = '0;
            exp_o = 1'b0;
        end else if (rem == 0) begin
            if (start) begin
                full_m = 32'(op_a) * 32'(op_b);
                pend_p = full_m[15:0];
                pend_o = (full_m[31:16] != 16'h0);
                rem    = lat_of(op_b);
            end
        end else begin
            rem = rem - 1;
            if (rem == 1) begin
                exp_p = pend_p;
                exp_o = pend_o;
            end
        end
    end

    always @(negedge clock) begin
        check("busy", 32'(busy), 32'(rem != 0));
        check("done", 32'(done), 32'(rem == 1));
        check("product", 32'(product), 32'(exp_p));
        check("mul_ovf", 32'(mul_ovf), 32'(exp_o));
        if (rem == 0) begin
            check("grant_op", 32'(alu_op), 32'(ctl_alu_op));
            check("grant_src", 32'({alu_src_a, alu_src_b}), 32'({ctl_src_a, ctl_src_b}));
            check("grant_data", {alu_mary, alu_shelley}, {ctl_mary, ctl_shelley});
        end else begin
            check("seq_op", 32'(alu_op), 32'h2);
            check("seq_src", 32'({alu_src_a, alu_src_b}), 32'h0);
        end
    end

    logic [15:0] mary_at    [0:127];
    logic [15:0] shelley_at [0:127];

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input bit poke,
                           input int unsigned want_lat, input logic [15:0] want_p,
                           input logic want_o, input string tag);
        int unsigned cyc;
        int unsigned got;
        @(posedge clock);
        #1 start = 1'b1;
        op_a = a;
        op_b = b;
        @(posedge clock);
        #1 start = 1'b0;
        op_a = 16'($urandom());
        op_b = 16'($urandom());
        cyc = 1;
        got = 0;
        while (cyc < 100) begin
            @(negedge clock);
            mary_at[cyc]    = alu_mary;
            shelley_at[cyc] = alu_shelley;
            if (done) begin
                got = cyc;
                break;
            end
            @(posedge clock);
            #1 start = poke && (cyc == 3);
            if (start) begin
                op_a = 16'($urandom());
                op_b = 16'($urandom());
            end
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, got, want_lat);
        check({tag, "_product"}, 32'(product), 32'(want_p));
        check({tag, "_ovf"}, 32'(mul_ovf), 32'(want_o));
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'($urandom_range(0, 255));
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        int w;
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_product", 32'(product), 32'h0);
        check("reset_ovf", 32'(mul_ovf), 32'h0);
        reset = 1'b1;

        @(posedge clock);
        #1 ctl_alu_op = 4'b1000;
        ctl_mary = 16'hA5A5;
        @(negedge clock);
        check("passthru_op", 32'(alu_op), 32'h8);
        check("passthru_mary", 32'(alu_mary), 32'hA5A5);

`ifdef MULSEQ_EARLY_TERM_EN
        run_mul(16'd3, 16'd5, 1'b1, 9, 16'd15, 1'b0, "mul3x5");
        run_mul(16'h1234, 16'h0000, 1'b0, 2, 16'h0000, 1'b0, "mulx0");
        run_mul(16'h0100, 16'h0100, 1'b1, 13, 16'h0000, 1'b1, "mul100sq");
        run_mul(16'h00FF, 16'h0101, 1'b0, 15, 16'hFFFF, 1'b0, "mulff");
`else
        run_mul(16'd3, 16'd5, 1'b1, 22, 16'd15, 1'b0, "mul3x5");
        run_mul(16'h1234, 16'h0000, 1'b0, 18, 16'h0000, 1'b0, "mulx0");
        run_mul(16'h0100, 16'h0100, 1'b1, 20, 16'h0000, 1'b1, "mul100sq");
        run_mul(16'h00FF, 16'h0101, 1'b0, 22, 16'hFFFF, 1'b0, "mulff");
`endif
        run_mul(16'hFFFF, 16'hFFFF, 1'b1, 50, 16'h0001, 1'b1, "mulffffsq");
        run_mul(16'd3, 16'd5, 1'b0, lat_of(16'd5), 16'd15, 1'b0, "mul3x5b");
        check("issue2_mary", 32'(mary_at[2]), 32'h0);
        check("issue2_shelley", 32'(shelley_at[2]), 32'h3);
        check("issue6_mary", 32'(mary_at[6]), 32'h3);
        check("issue6_shelley", 32'(shelley_at[6]), 32'hC);

        // Leave a nonzero product, then reset in the middle of a run.
        run_mul(16'h00FF, 16'h0101, 1'b0, lat_of(16'h0101), 16'hFFFF, 1'b0, "prereset");
        @(posedge clock);
        #1 start = 1'b1;
        op_a = 16'hFFFF;
        op_b = 16'hFFFF;
        ctl_alu_op = 4'b0110;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (6) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'h0);
        check("midreset_product", 32'(product), 32'h0);
        check("midreset_ovf", 32'(mul_ovf), 32'h0);
        check("midreset_grant", 32'(alu_op), 32'h6);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 400; i++) begin
            @(posedge clock);
            #1 start = ($urandom_range(0, 2) == 0);
            op_a        = pick();
            op_b        = pick();
            ctl_src_a   = 1'($urandom());
            ctl_src_b   = 2'($urandom());
            ctl_alu_op  = 4'($urandom());
            ctl_mary    = 16'($urandom());
            ctl_shelley = 16'($urandom());
        end
        start = 1'b0;

        w = 0;
        while (busy && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("final_idle", 32'(busy), 32'h0);
        repeat (2) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
